// File: rtl/ps2_hex_ctrl_if.sv
// Byte stream from a PS/2 receiver into ps2_hex_ctrl.
// A byte is accepted on any cycle with byte_valid and byte_ready both high.
interface ps2_hex_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/ps2_hex_ctrl.sv
// PS/2 scan-code parser that shows the last key code, extension flag and press count on six 7-segment digits.
// Optional idle blanking of the digits is built when PS2_HEX_BLANK_EN is defined.
module ps2_hex_ctrl #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  ps2_hex_ctrl_if.slave    bus,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [7:0]       LEDR
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  state_t      state_reg, state_next;
  logic [7:0]  key_code_reg;
  logic        ext_reg;
  logic        key_down_reg;
  logic [7:0]  press_count_reg;
  logic        ready_reg;
  logic        blank;

  logic        accept;
  logic        is_make;
  logic        is_break;
  logic        ev_ext;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign accept         = bus.byte_valid & ready_reg;
  assign bus.byte_ready = ready_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
    end
  end

  // Prefix bytes only move the FSM; the final byte of a sequence raises a make or break event.
  always_comb begin
    state_next = state_reg;
    is_make    = 1'b0;
    is_break   = 1'b0;
    ev_ext     = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (bus.byte_in == 8'hE0)      state_next = GOT_E0;
          else if (bus.byte_in == 8'hF0) state_next = GOT_F0;
          else                           is_make    = 1'b1;
        end
        GOT_E0: begin
          if (bus.byte_in == 8'hF0)      state_next = GOT_E0F0;
          else if (bus.byte_in == 8'hE0) state_next = GOT_E0;
          else begin
            is_make    = 1'b1;
            ev_ext     = 1'b1;
            state_next = IDLE;
          end
        end
        GOT_F0: begin
          is_break   = 1'b1;
          state_next = IDLE;
        end
        GOT_E0F0: begin
          is_break   = 1'b1;
          ev_ext     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_code_reg    <= 8'h00;
      ext_reg         <= 1'b0;
      key_down_reg    <= 1'b0;
      press_count_reg <= 8'h00;
    end else if (is_make) begin
      // A make matching the held key is typematic repeat and is ignored.
      if (!(key_down_reg && key_code_reg == bus.byte_in && ext_reg == ev_ext)) begin
        key_code_reg    <= bus.byte_in;
        ext_reg         <= ev_ext;
        key_down_reg    <= 1'b1;
        press_count_reg <= press_count_reg + 8'd1;
      end
    end else if (is_break) begin
      if (key_code_reg == bus.byte_in && ext_reg == ev_ext)
        key_down_reg <= 1'b0;
    end
  end

`ifdef PS2_HEX_BLANK_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_count_reg;
  logic          blank_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idle_count_reg <= '0;
      blank_reg      <= 1'b0;
    end else if (accept) begin
      idle_count_reg <= '0;
      blank_reg      <= 1'b0;
    end else begin
      if (idle_count_reg != IDLE_LAST)
        idle_count_reg <= idle_count_reg + 1'b1;
      else
        blank_reg <= 1'b1;
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

  // Display stage lags the parser state by one cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      HEX0 <= 7'h40;
      HEX1 <= 7'h40;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= 7'h40;
      HEX5 <= 7'h40;
      LEDR <= 8'h00;
    end else begin
      HEX0 <= blank ? SEG_BLANK : hex_glyph(key_code_reg[3:0]);
      HEX1 <= blank ? SEG_BLANK : hex_glyph(key_code_reg[7:4]);
      HEX2 <= (blank || !ext_reg) ? SEG_BLANK : SEG_E;
      HEX3 <= SEG_BLANK;
      HEX4 <= blank ? SEG_BLANK : hex_glyph(press_count_reg[3:0]);
      HEX5 <= blank ? SEG_BLANK : hex_glyph(press_count_reg[7:4]);
      LEDR <= {4'b0000, state_reg, ext_reg, key_down_reg};
    end
  end

endmodule
